// File: rtl/key_note_selector.sv
// Piano key front end: synchronises and debounces 24 keys (C4..B5), then picks the
// key offset for the frequency lookup using last-note priority (24 = no note).
module key_note_selector #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] Keys,
  output logic [4:0]  Offset,
  output logic        NoteOn,
  output logic        NoteChange
);

  localparam int             NK        = 24;
  localparam int             TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]     CNT_LAST  = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [4:0]     NO_NOTE   = 5'd24;

  logic [NK-1:0] sync1_q, sync2_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          sample_tick;
  logic [NK-1:0] stable_q, stable_d;
  logic [NK-1:0] stable_prev_q;
  logic [7:0]    cnt_q [NK];
  logic [7:0]    cnt_d [NK];
  logic [NK-1:0] pressed, released;
  logic [4:0]    offset_q, offset_d;
  logic          note_on_q, note_on_d;
  logic          note_change_q, note_change_d;

  function automatic logic [4:0] lowest_set(input logic [NK-1:0] v);
    lowest_set = NO_NOTE;
    for (int i = NK - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

  // Shared prescaler: one sample tick every TICK_DIV cycles for all keys.
  always_comb begin
    sample_tick = (tick_cnt_q == TICK_LAST);
    tick_cnt_d  = sample_tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NK; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample_tick) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Newest press wins; releasing the sounding key falls back to the lowest held key.
  always_comb begin
    pressed  = stable_q & ~stable_prev_q;
    released = ~stable_q & stable_prev_q;
    offset_d = offset_q;
    if (pressed != '0) begin
      offset_d = lowest_set(pressed);
    end else if (offset_q != NO_NOTE && released[offset_q]) begin
      offset_d = lowest_set(stable_q);
    end
    note_change_d = (offset_d != offset_q);
    note_on_d     = (offset_d != NO_NOTE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      tick_cnt_q    <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
      offset_q      <= NO_NOTE;
      note_on_q     <= 1'b0;
      note_change_q <= 1'b0;
    end else begin
      sync1_q       <= Keys;
      sync2_q       <= sync1_q;
      tick_cnt_q    <= tick_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < NK; i++) cnt_q[i] <= cnt_d[i];
      offset_q      <= offset_d;
      note_on_q     <= note_on_d;
      note_change_q <= note_change_d;
    end
  end

  assign Offset     = offset_q;
  assign NoteOn     = note_on_q;
  assign NoteChange = note_change_q;

endmodule

// File: tb/tb_key_note_selector.sv
// Bench for key_note_selector: directed scenarios plus random key activity, every
// cycle compared against a behavioural model of the key-to-offset rules.
module tb_key_note_selector;

  localparam int TICK_DIV = 4;
  localparam int DB       = 3;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [23:0] Keys  = '1;
  logic [4:0]  Offset;
  logic        NoteOn;
  logic        NoteChange;

  key_note_selector #(.TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DB)) dut (
    .Clk(Clk), .Reset(Reset), .Keys(Keys),
    .Offset(Offset), .NoteOn(NoteOn), .NoteChange(NoteChange)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [23:0] m_hist1, m_hist2;  // key levels seen one and two edges ago
  logic [23:0] m_held, m_held_before;
  int          m_run [24];        // consecutive disagreeing ticks per key
  int          m_cycle;
  int          m_off;
  bit          m_on, m_chg;
  bit          started = 0;

  function automatic int lowest_of(input logic [23:0] v);
    for (int i = 0; i < 24; i++) if (v[i]) return i;
    return 24;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_hist1 = '0; m_hist2 = '0; m_held = '0; m_held_before = '0;
      for (int i = 0; i < 24; i++) m_run[i] = 0;
      m_cycle = 0; m_off = 24; m_on = 0; m_chg = 0;
    end else begin
      logic [23:0] new_press, new_rel;
      int          nxt;
      new_press = m_held & ~m_held_before;
      new_rel   = m_held_before & ~m_held;
      nxt = m_off;
      if (new_press != 0) nxt = lowest_of(new_press);
      else if (m_off < 24 && new_rel[m_off]) nxt = lowest_of(m_held);
      m_chg = (nxt != m_off);
      m_on  = (nxt != 24);
      m_off = nxt;
      m_held_before = m_held;
      if (m_cycle % TICK_DIV == TICK_DIV - 1) begin
        for (int i = 0; i < 24; i++) begin
          if (m_hist2[i] != m_held[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin
              m_held[i] = m_hist2[i];
              m_run[i]  = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_cycle = m_cycle + 1;
      m_hist2 = m_hist1;
      m_hist1 = Keys;
    end
    started = 1;
  end

  always @(negedge Clk) begin
    if (started) begin
      check_val("model_offset", Offset, m_off);
      check_val("model_note_on", NoteOn, m_on);
      check_val("model_note_change", NoteChange, m_chg);
      check_val("offset_range", Offset <= 5'd24, 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) begin
      @(negedge Clk);
      if (NoteChange) pulses++;
    end
  endtask

  task automatic wait_change(input string tag, input int budget, input int exp, output int lat);
    bit found = 0;
    lat = 0;
    while (!found && lat < budget) begin
      @(negedge Clk);
      lat++;
      if (NoteChange) begin
        pulses++;
        found = 1;
      end
    end
    check_val({tag, "_seen"}, found, 1);
    if (found) check_val(tag, Offset, exp);
  endtask

  function automatic logic [23:0] bitk(input int k);
    logic [23:0] one = 24'd1;
    return one << k;
  endfunction

  initial begin
    int lat;
    // reset held with all keys down
    Keys = '1; Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check_val("rst_offset", Offset, 24);
      check_val("rst_note_on", NoteOn, 0);
      check_val("rst_note_change", NoteChange, 0);
    end
    Reset = 1'b0;
    pulses = 0;
    wait_change("rst_release_lowest", 40, 0, lat);
    run(20);
    check_val("rst_release_pulses", pulses, 1);
    Keys = '0;
    wait_change("all_release", 40, 24, lat);
    run(10);

    // single press / release of A4
    pulses = 0;
    Keys = bitk(9);
    wait_change("press9", 40, 9, lat);
    check_val("press9_lat_max", lat <= 15, 1);
    check_val("press9_lat_min", lat >= 11, 1);
    check_val("press9_note_on", NoteOn, 1);
    run(20);
    Keys = '0;
    wait_change("release9", 40, 24, lat);
    check_val("release9_note_on", NoteOn, 0);
    run(10);
    check_val("press9_pulses", pulses, 2);

    // last-note priority
    pulses = 0;
    Keys = bitk(4);
    wait_change("prio_first", 40, 4, lat);
    run(5);
    Keys = Keys | bitk(11);
    wait_change("prio_newest", 40, 11, lat);
    run(5);
    Keys = Keys & ~bitk(11);
    wait_change("prio_fallback", 40, 4, lat);
    run(10);
    check_val("prio_pulses", pulses, 3);
    Keys = '0;
    wait_change("prio_clear", 40, 24, lat);
    run(10);

    // releasing a held but unselected key
    Keys = bitk(2);
    wait_change("nonsel_first", 40, 2, lat);
    Keys = Keys | bitk(7);
    wait_change("nonsel_second", 40, 7, lat);
    run(5);
    pulses = 0;
    Keys = Keys & ~bitk(2);
    run(30);
    check_val("nonsel_offset", Offset, 7);
    check_val("nonsel_pulses", pulses, 0);
    Keys = '0;
    wait_change("nonsel_clear", 40, 24, lat);
    run(10);

    // short glitch is rejected
    pulses = 0;
    Keys = bitk(15);
    run(6);
    Keys = '0;
    run(30);
    check_val("glitch_offset", Offset, 24);
    check_val("glitch_pulses", pulses, 0);

    // reset while a key is sounding
    Keys = bitk(11);
    wait_change("midrst_pre", 40, 11, lat);
    run(3);
    Reset = 1'b1;
    @(negedge Clk);
    check_val("midrst_offset", Offset, 24);
    check_val("midrst_note_on", NoteOn, 0);
    check_val("midrst_note_change", NoteChange, 0);
    Reset = 1'b0;
    pulses = 0;
    wait_change("midrst_redetect", 40, 11, lat);
    check_val("midrst_redetect_lat", lat >= 11, 1);
    run(20);
    check_val("midrst_pulses", pulses, 1);

    // random key activity, glitches and occasional resets
    for (int it = 0; it < 220; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) Keys = 24'($urandom()) & 24'($urandom()) & 24'($urandom());
      else if (r < 7) Keys = Keys ^ bitk($urandom_range(0, 23));
      else if (r < 9) Keys = Keys & ~bitk($urandom_range(0, 23));
      else Keys = '0;
      if ($urandom_range(0, 60) == 0) begin
        Reset = 1'b1;
        run(1);
        Reset = 1'b0;
      end
      run($urandom_range(1, 24));
    end
    Keys = '0;
    run(30);
    check_val("final_offset", Offset, 24);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
